// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Multi-cycle unsigned MUL/DIV sequencer: one iteration per cycle, result
// latched into HI/LO on the edge entering DONE, start/busy/done handshake.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] in_s1,
  input  logic [WIDTH-1:0] in_s2,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  muldiv_state_t r_state;
  muldiv_state_t w_next_state;

  // Shared operand registers: r_opa is multiplicand (MUL) or the dividend
  // shifted out MSB-first (DIV); r_opb is the divisor. The multiplier lives
  // in the low half of the accumulator.
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  logic               w_last;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  assign w_last = (r_cnt == LAST);

  // State register; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: start only in IDLE, abort only while iterating.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MUL: w_next_state = MUL;
            OP_DIV: w_next_state = DIV;
            default: w_next_state = IDLE;
          endcase
        end
      end
      MUL, DIV: begin
        if (abort)       w_next_state = IDLE;
        else if (w_last) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // One iteration of each datapath. The 2W+1-bit shift-add accumulator exists
  // only transiently: the carry bit is the top of w_mul_sum and is consumed by
  // the right shift, so r_acc stores 2W bits. Likewise the W+1-bit remainder
  // is w_rem_sh; after the conditional subtract it always fits W bits.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
    w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_rem_sh   = {r_rem, r_opa[WIDTH-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_opb});
    w_rem_next = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_opb}) : w_rem_sh[WIDTH-1:0];
    w_quo_next = {r_quo[WIDTH-2:0], w_ge};
  end

  // Datapath and architectural HI/LO; HI/LO/flag change only on the final
  // iteration edge, so abort leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa <= '0;
      r_opb <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_dbz <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_opa <= in_s1;
            r_opb <= in_s2;
            r_cnt <= '0;
            r_acc <= {{WIDTH{1'b0}}, in_s2};
            r_rem <= '0;
            r_quo <= '0;
          end
        end
        MUL: begin
          if (!abort) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_hi  <= w_acc_next[2*WIDTH-1:WIDTH];
              r_lo  <= w_acc_next[WIDTH-1:0];
              r_dbz <= 1'b0;
            end
          end
        end
        DIV: begin
          if (!abort) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_opa <= {r_opa[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_hi  <= w_rem_next;
              r_lo  <= w_quo_next;
              r_dbz <= (r_opb == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  always_comb begin
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    hi          = r_hi;
    lo          = r_lo;
    div_by_zero = r_dbz;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int W     = 32;
  localparam int ITERS = 32;
  localparam int LAT   = ITERS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] in_s1;
  logic [W-1:0] in_s2;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.WIDTH(W), .ITERS(ITERS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_s1(in_s1),
    .in_s2(in_s2), .abort(abort), .busy(busy), .done(done), .hi(hi),
    .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el,
                                output logic ez);
    logic [2*W-1:0] p;
    if (o == 1'b0) begin
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      eh = p[2*W-1:W];
      el = p[W-1:0];
      ez = 1'b0;
    end else if (b == 0) begin
      eh = a;
      el = {W{1'b1}};
      ez = 1'b1;
    end else begin
      eh = a % b;
      el = a / b;
      ez = 1'b0;
    end
  endfunction

  // Issues one op and observes it for a bounded window (no checks here).
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int done_cyc, output int n_done, output bit busy_ok,
                        output logic [W-1:0] ho, output logic [W-1:0] lo_o, output logic zo);
    start = 1'b1; op = o; in_s1 = a; in_s2 = b;
    tick();
    start = 1'b0;
    done_cyc = -1; n_done = 0; busy_ok = 1'b1;
    ho = 'x; lo_o = 'x; zo = 1'bx;
    for (int c = 1; c <= LAT + 6; c++) begin
      if (done) begin
        if (n_done == 0) begin
          done_cyc = c; ho = hi; lo_o = lo; zo = div_by_zero;
        end
        n_done++;
      end
      if (c <= LAT && !busy) busy_ok = 1'b0;
      if (c == LAT + 1 && busy) busy_ok = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; in_s1 = '0; in_s2 = '0; abort = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, hi, lo, div_by_zero} !== {2'b00, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h dbz=%b required all zero",
               busy, done, hi, lo, div_by_zero);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mul_directed();
    logic [W-1:0] a[2], b[2], ho, lo_o, eh, el;
    logic zo, ez;
    int dc, nd;
    bit bok;
    a[0] = 32'h0000FFFF; b[0] = 32'h00010000;
    a[1] = 32'hFFFFFFFF; b[1] = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, a[i], b[i], dc, nd, bok, ho, lo_o, zo);
      model(1'b0, a[i], b[i], eh, el, ez);
      checks++;
      if (dc !== LAT || nd !== 1) begin
        errors++; $display("FAIL mul_done_cycle[%0d]: cycle=%0d pulses=%0d required %0d/1", i, dc, nd, LAT);
      end
      checks++;
      if ({ho, lo_o, zo} !== {eh, el, ez}) begin
        errors++; $display("FAIL mul_result[%0d]: hi=%h lo=%h dbz=%b required %h %h %b", i, ho, lo_o, zo, eh, el, ez);
      end
    end
  endtask

  task automatic test_div_directed();
    logic [W-1:0] ho, lo_o;
    logic zo;
    int dc, nd;
    bit bok;
    run_op(1'b1, 32'd100, 32'd7, dc, nd, bok, ho, lo_o, zo);
    checks++;
    if (lo_o !== 32'd14 || ho !== 32'd2 || zo !== 1'b0) begin
      errors++; $display("FAIL div_100_7: lo=%0d hi=%0d dbz=%b required 14 2 0", lo_o, ho, zo);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++; $display("FAIL div_busy_window: busy_ok=%b required 1", bok);
    end
    checks++;
    if (dc !== LAT || nd !== 1) begin
      errors++; $display("FAIL div_done_cycle: cycle=%0d pulses=%0d required %0d/1", dc, nd, LAT);
    end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] ho, lo_o;
    logic zo;
    int dc, nd;
    bit bok;
    run_op(1'b1, 32'h00001234, 32'd0, dc, nd, bok, ho, lo_o, zo);
    checks++;
    if (lo_o !== 32'hFFFFFFFF || ho !== 32'h00001234 || zo !== 1'b1 || dc !== LAT) begin
      errors++; $display("FAIL div_by_zero: lo=%h hi=%h dbz=%b cyc=%0d required ffffffff 00001234 1 %0d",
                         lo_o, ho, zo, dc, LAT);
    end
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_sticky: dbz=%b required 1", div_by_zero);
    end
    run_op(1'b0, 32'd2, 32'd3, dc, nd, bok, ho, lo_o, zo);
    checks++;
    if (lo_o !== 32'd6 || ho !== 32'd0 || zo !== 1'b0) begin
      errors++; $display("FAIL dbz_clear_by_mul: lo=%0d hi=%0d dbz=%b required 6 0 0", lo_o, ho, zo);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] ho, lo_o;
    logic zo;
    int dc, nd;
    bit bok;
    int seen;
    run_op(1'b0, 32'd3, 32'd5, dc, nd, bok, ho, lo_o, zo);
    checks++;
    if (lo_o !== 32'd15) begin
      errors++; $display("FAIL abort_pre_mul: lo=%0d required 15", lo_o);
    end
    start = 1'b1; op = 1'b1; in_s1 = 32'd50; in_s2 = 32'd5;
    tick();
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      start = (c == 5);
      abort = (c == 10);
      if (done) seen++;
      tick();
    end
    // cycle 11
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || seen !== 0) begin
      errors++; $display("FAIL abort_to_idle: busy=%b done=%b dones_seen=%0d required 0 0 0", busy, done, seen);
    end
    checks++;
    if (lo !== 32'd15 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL abort_hold_hilo: lo=%0d hi=%0d dbz=%b required 15 0 0", lo, hi, div_by_zero);
    end
    // start together with abort in IDLE: start wins
    start = 1'b1; abort = 1'b1; op = 1'b1; in_s1 = 32'd50; in_s2 = 32'd5;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_restart_accept: busy=%b required 1", busy);
    end
    dc = -1;
    for (int c = 1; c <= LAT + 5; c++) begin
      if (done && dc < 0) begin dc = c; ho = hi; lo_o = lo; end
      tick();
    end
    checks++;
    if (dc !== LAT || lo_o !== 32'd10 || ho !== 32'd0) begin
      errors++; $display("FAIL abort_restart_result: cyc=%0d lo=%0d hi=%0d required %0d 10 0", dc, lo_o, ho, LAT);
    end
  endtask

  task automatic test_rst_mid();
    int seen;
    start = 1'b1; op = 1'b1; in_s1 = 32'hDEADBEEF; in_s2 = 32'd9;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, hi, lo, div_by_zero} !== {2'b00, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      errors++; $display("FAIL rst_mid_op: busy=%b done=%b hi=%h lo=%h dbz=%b required all zero",
                         busy, done, hi, lo, div_by_zero);
    end
    seen = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      if (done || busy) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_mid_no_done: active_cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int dcyc[$];
    logic [W-1:0] his[$], los[$];
    logic [W-1:0] eh, el;
    logic ez;
    start = 1'b1; op = 1'b0; in_s1 = 32'h12345678; in_s2 = 32'h9ABCDEF0;
    tick();
    for (int c = 1; c <= 2 * LAT + 8; c++) begin
      if (c == 1) begin op = 1'b1; in_s1 = 32'hCAFEF00D; in_s2 = 32'h00000123; end
      if (c == LAT + 2) start = 1'b0;
      if (c == LAT + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL b2b_start_ignored_in_done: busy=%b required 0", busy);
        end
      end
      if (done) begin dcyc.push_back(c); his.push_back(hi); los.push_back(lo); end
      tick();
    end
    start = 1'b0;
    checks++;
    if (dcyc.size() !== 2) begin
      errors++; $display("FAIL b2b_done_count: count=%0d required 2", dcyc.size());
    end else begin
      checks++;
      if (dcyc[0] !== LAT || dcyc[1] !== 2 * LAT + 1) begin
        errors++; $display("FAIL b2b_done_cycles: %0d,%0d required %0d,%0d", dcyc[0], dcyc[1], LAT, 2 * LAT + 1);
      end
      model(1'b0, 32'h12345678, 32'h9ABCDEF0, eh, el, ez);
      checks++;
      if (his[0] !== eh || los[0] !== el) begin
        errors++; $display("FAIL b2b_first_mul: hi=%h lo=%h required %h %h", his[0], los[0], eh, el);
      end
      model(1'b1, 32'hCAFEF00D, 32'h00000123, eh, el, ez);
      checks++;
      if (his[1] !== eh || los[1] !== el) begin
        errors++; $display("FAIL b2b_second_div: hi=%h lo=%h required %h %h", his[1], los[1], eh, el);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, ho, lo_o, eh, el;
    logic o, zo, ez;
    int dc, nd;
    bit bok;
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op(o, a, b, dc, nd, bok, ho, lo_o, zo);
      model(o, a, b, eh, el, ez);
      checks++;
      if ({ho, lo_o, zo} !== {eh, el, ez} || dc !== LAT || nd !== 1 || bok !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: hi=%h lo=%h dbz=%b cyc=%0d n=%0d busy_ok=%b required %h %h %b %0d 1 1",
                 i, o, a, b, ho, lo_o, zo, dc, nd, bok, eh, el, ez, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_div_by_zero();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
